// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the LEGv8 instruction fetch stage: widths, reset PC, step and FSM states.
package instruction_fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 64;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned CNT_W       = 32;

    localparam logic [63:0] RESET_PC_DEF = 64'h0;
    localparam int unsigned PC_STEP      = 4;

    // Fetch FSM encoding
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Memory request/ack and datapath handoff bundle for the fetch stage.
// master = fetch stage, slave = memory + datapath side.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
);

    logic               oMemReq;
    logic [ADDR_W-1:0]  oMemAddr;
    logic               iMemAck;
    logic [INSTR_W-1:0] iMemData;
    logic [INSTR_W-1:0] oInstr;
    logic               oInstrValid;
    logic [ADDR_W-1:0]  oPC;
    logic               iInstrAccept;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic [CNT_W-1:0]   oFetchCount;
    logic [CNT_W-1:0]   oStallCycles;

    modport master (
        output oMemReq, oMemAddr, oInstr, oInstrValid, oPC, oFetchCount, oStallCycles,
        input  iMemAck, iMemData, iInstrAccept, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oMemReq, oMemAddr, oInstr, oInstrValid, oPC, oFetchCount, oStallCycles,
        output iMemAck, iMemData, iInstrAccept, iBranchTaken, iBranchTarget
    );

endinterface : instruction_fetch_if

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: word-aligned branch target when taken, else PC + 4 (wraps).
module fetch_next_pc
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] fetch_pc_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    // Low target bits are discarded by alignment
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target_i[1:0];

    // Branch target wins over sequential step
    always_comb begin
        next_pc_o = fetch_pc_i + ADDR_W'(PC_STEP);
        if (branch_taken_i) begin
            next_pc_o = {branch_target_i[ADDR_W-1:2], 2'b00};
        end
    end

endmodule : fetch_next_pc

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: owns the PC, issues one-cycle read requests, holds the fetched word
// with its PC until the datapath accepts it, then redirects or advances by 4.
// Optional per-stage counters are built when IFETCH_STATS_EN is defined.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                iCLK,
    input  logic                iReset,
    instruction_fetch_if.master bus
);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  next_pc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               mem_req_q, mem_req_d;

    fetch_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .fetch_pc_i      (fetch_pc_q),
        .branch_taken_i  (bus.iBranchTaken),
        .branch_target_i (bus.iBranchTarget),
        .next_pc_o       (next_pc)
    );

    // Next-state and holding-register update
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        mem_req_d  = 1'b0;

        case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.iMemAck) begin
                    instr_d = bus.iMemData;
                    pc_d    = fetch_pc_q;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.iInstrAccept) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = next_pc;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Request is a registered decode of the upcoming state
        mem_req_d = (state_d == S_REQ);
    end

    // State and output registers
    always_ff @(posedge iCLK or negedge iReset) begin
        if (!iReset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            instr_q    <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            mem_req_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign bus.oMemReq     = mem_req_q;
    assign bus.oMemAddr    = fetch_pc_q;
    assign bus.oInstr      = instr_q;
    assign bus.oPC         = pc_q;
    assign bus.oInstrValid = valid_q;

`ifdef IFETCH_STATS_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Accepted-instruction and stalled-hold counters, free-running with wrap
    always_ff @(posedge iCLK or negedge iReset) begin
        if (!iReset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid_q && bus.iInstrAccept) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if (valid_q && !bus.iInstrAccept) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.oFetchCount  = fetch_cnt_q;
    assign bus.oStallCycles = stall_cnt_q;
`else
    assign bus.oFetchCount  = '0;
    assign bus.oStallCycles = '0;
`endif

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, random transactions against a PC/counter
// model, and a reset-during-wait sequence with a stale acknowledge.
module tb_instruction_fetch;

    logic clk;
    logic rst_n;

    instruction_fetch_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    instruction_fetch dut (
        .iCLK   (clk),
        .iReset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [63:0] model_pc;
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    typedef struct {
        int          d;
        int          h;
        bit          br;
        logic [63:0] tgt;
        logic [31:0] data;
        logic [63:0] pc;
        logic [63:0] nxt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef IFETCH_STATS_EN
        chk({tag, "_fetch_count"}, 64'(bus.oFetchCount), 64'(exp_fetch));
        chk({tag, "_stall_cycles"}, 64'(bus.oStallCycles), 64'(exp_stall));
`else
        chk({tag, "_fetch_count"}, 64'(bus.oFetchCount), 64'd0);
        chk({tag, "_stall_cycles"}, 64'(bus.oStallCycles), 64'd0);
`endif
    endtask

    // One full fetch: wait for req, ack after d cycles, hold h cycles, accept with optional branch
    task automatic do_txn(input int d, input int h, input bit br, input logic [63:0] tgt,
                          input logic [31:0] data, input logic [63:0] exp_pc,
                          input logic [63:0] exp_next, input bit noise, input bit stale);
        int n;
        n = 0;
        while (bus.oMemReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 64'(bus.oMemReq), 64'd1);
        if (bus.oMemReq !== 1'b1) return;
        chk("req_addr", bus.oMemAddr, exp_pc);

        // Ack in the request cycle must be dropped
        bus.iMemAck  = stale;
        bus.iMemData = 32'hDEAD_BEEF;
        for (int k = 1; k < d; k++) begin
            @(negedge clk);
            bus.iMemAck = 1'b0;
            chk("req_pulse", 64'(bus.oMemReq), 64'd0);
            chk("valid_early", 64'(bus.oInstrValid), 64'd0);
        end
        @(negedge clk);
        chk("req_pulse", 64'(bus.oMemReq), 64'd0);
        chk("valid_at_ack", 64'(bus.oInstrValid), 64'd0);
        bus.iMemAck  = 1'b1;
        bus.iMemData = data;

        @(negedge clk);
        bus.iMemAck  = 1'b0;
        bus.iMemData = 32'h0;
        chk("valid_after_ack", 64'(bus.oInstrValid), 64'd1);
        chk("instr", 64'(bus.oInstr), 64'(data));
        chk("pc", bus.oPC, exp_pc);

        for (int j = 0; j < h; j++) begin
            bus.iInstrAccept  = 1'b0;
            bus.iBranchTaken  = noise;
            bus.iBranchTarget = noise ? {$urandom, $urandom} : 64'h0;
            bus.iMemAck       = noise;
            bus.iMemData      = 32'hBAD0_0BAD;
            exp_stall++;
            @(negedge clk);
            chk("hold_valid", 64'(bus.oInstrValid), 64'd1);
            chk("hold_instr", 64'(bus.oInstr), 64'(data));
            chk("hold_pc", bus.oPC, exp_pc);
            chk("hold_req", 64'(bus.oMemReq), 64'd0);
        end

        bus.iMemAck       = 1'b0;
        bus.iInstrAccept  = 1'b1;
        bus.iBranchTaken  = br;
        bus.iBranchTarget = tgt;
        exp_fetch++;
        @(negedge clk);
        bus.iInstrAccept  = 1'b0;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 64'h0;
        chk("next_req", 64'(bus.oMemReq), 64'd1);
        chk("next_addr", bus.oMemAddr, exp_next);
        chk("valid_cleared", 64'(bus.oInstrValid), 64'd0);
        chk_counters("txn");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tgt;
        logic [63:0] nxt;
        bit          br;

        tbl[0] = '{d: 1, h: 0, br: 1'b0, tgt: 64'h0,                   data: 32'h8B02_0020,
                   pc: 64'h0,                   nxt: 64'h4};
        tbl[1] = '{d: 5, h: 0, br: 1'b0, tgt: 64'h0,                   data: 32'h1111_1111,
                   pc: 64'h4,                   nxt: 64'h8};
        tbl[2] = '{d: 2, h: 4, br: 1'b0, tgt: 64'h0,                   data: 32'h2222_2222,
                   pc: 64'h8,                   nxt: 64'hC};
        tbl[3] = '{d: 1, h: 2, br: 1'b1, tgt: 64'h103,                 data: 32'h3333_3333,
                   pc: 64'hC,                   nxt: 64'h100};
        tbl[4] = '{d: 3, h: 0, br: 1'b1, tgt: 64'hFFFF_FFFF_FFFF_FFFF, data: 32'h4444_4444,
                   pc: 64'h100,                 nxt: 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[5] = '{d: 1, h: 1, br: 1'b0, tgt: 64'h0,                   data: 32'h5555_5555,
                   pc: 64'hFFFF_FFFF_FFFF_FFFC, nxt: 64'h0};
        tbl[6] = '{d: 4, h: 0, br: 1'b0, tgt: 64'h0,                   data: 32'h6666_6666,
                   pc: 64'h0,                   nxt: 64'h4};

        rst_n             = 1'b0;
        bus.iMemAck       = 1'b0;
        bus.iMemData      = 32'h0;
        bus.iInstrAccept  = 1'b0;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 64'h0;
        model_pc  = 64'h0;
        exp_fetch = 32'd0;
        exp_stall = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_req", 64'(bus.oMemReq), 64'd1);
        chk("rst_addr", bus.oMemAddr, 64'h0);
        chk("rst_valid", 64'(bus.oInstrValid), 64'd0);
        chk("rst_instr", 64'(bus.oInstr), 64'd0);
        chk("rst_pc", bus.oPC, 64'h0);
        chk_counters("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].d, tbl[i].h, tbl[i].br, tbl[i].tgt, tbl[i].data,
                   tbl[i].pc, tbl[i].nxt, bit'(i % 2), 1'b0);
            model_pc = tbl[i].nxt;
        end

        for (int i = 0; i < 40; i++) begin
            br  = bit'($urandom_range(0, 1));
            tgt = {$urandom, $urandom};
            nxt = br ? (tgt & ~64'h3) : (model_pc + 64'd4);
            do_txn(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), br, tgt, $urandom,
                   model_pc, nxt, bit'($urandom_range(0, 1)), 1'b0);
            model_pc = nxt;
        end

        // Reset while waiting for an ack; the stale ack after release must be dropped
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_pc  = 64'h0;
        exp_fetch = 32'd0;
        exp_stall = 32'd0;
        chk("midrst_req", 64'(bus.oMemReq), 64'd1);
        chk("midrst_addr", bus.oMemAddr, 64'h0);
        chk("midrst_valid", 64'(bus.oInstrValid), 64'd0);
        chk_counters("midrst");
        rst_n = 1'b1;
        do_txn(2, 1, 1'b0, 64'h0, 32'hA5A5_5A5A, 64'h0, 64'h4, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch
